// File: rtl/digit_box_pkg.sv
// rtl/digit_box_pkg.sv - shared types for digit_box_overlay (DIGIT_BOX_FILL_EN selects interior fill)
package digit_box_pkg;

    localparam int COORD_W = 11;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [23:0]        rgb_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ARMED
    } state_t;

    typedef struct packed {
        coord_t l;
        coord_t r;
        coord_t t;
        coord_t b;
    } box_t;

    // Per-channel (a+b)>>1 with the carry kept so the result is a true 8-bit truncation.
    function automatic rgb_t rgb_avg(input rgb_t a, input rgb_t b);
        logic [8:0] s_r;
        logic [8:0] s_g;
        logic [8:0] s_b;
        s_r = {1'b0, a[23:16]} + {1'b0, b[23:16]};
        s_g = {1'b0, a[15:8]}  + {1'b0, b[15:8]};
        s_b = {1'b0, a[7:0]}   + {1'b0, b[7:0]};
        return {s_r[8:1], s_g[8:1], s_b[8:1]};
    endfunction

endpackage

// File: rtl/digit_box_overlay_box_hit.sv
// rtl/digit_box_overlay_box_hit.sv - combinational outline/interior test for one box (DIGIT_BOX_FILL_EN adds inside)
module box_hit
    import digit_box_pkg::*;
#(
    parameter int LINE_W = 2
) (
    input  logic   en,
    input  box_t   box,
    input  coord_t x,
    input  coord_t y,
`ifdef DIGIT_BOX_FILL_EN
    output logic   inside,
`endif
    output logic   hit
);

    localparam coord_t LW = coord_t'(LINE_W);

    logic valid;
    logic in_x;
    logic in_y;
    logic on_l;
    logic on_r;
    logic on_t;
    logic on_b;
    logic edge_hit;

    assign valid = en && (box.l < box.r) && (box.t < box.b);
    assign in_x  = (x >= box.l) && (x <= box.r);
    assign in_y  = (y >= box.t) && (y <= box.b);

    // Distance form keeps the band correct even when r or b is smaller than LINE_W-1.
    assign on_l  = (x >= box.l) && ((x - box.l) < LW);
    assign on_r  = (x <= box.r) && ((box.r - x) < LW);
    assign on_t  = (y >= box.t) && ((y - box.t) < LW);
    assign on_b  = (y <= box.b) && ((box.b - y) < LW);

    assign edge_hit = (in_y && (on_l || on_r)) || (in_x && (on_t || on_b));
    assign hit      = valid && edge_hit;

`ifdef DIGIT_BOX_FILL_EN
    assign inside = valid && in_x && in_y && !edge_hit;
`endif

endmodule

// File: rtl/digit_box_overlay.sv
// rtl/digit_box_overlay.sv - latches digit boxes from border RAMs and draws outlines on video (DIGIT_BOX_FILL_EN fills interiors)
module digit_box_overlay
    import digit_box_pkg::*;
#(
    parameter int          NUM_ROW   = 1,
    parameter int          NUM_COL   = 3,
    parameter int          H_PIXEL   = 1280,
    parameter int          V_PIXEL   = 720,
    parameter int          DEPBIT    = 13,
    parameter int          LINE_W    = 2,
    parameter logic [23:0] BOX_COLOR = 24'hFF0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              project_done_flag,
    input  logic [3:0]        num_col,
    input  logic [3:0]        num_row,
    output logic [DEPBIT-1:0] col_border_addr_rd,
    input  logic [DEPBIT-1:0] col_border_data_rd,
    output logic [DEPBIT-1:0] row_border_addr_rd,
    input  logic [DEPBIT-1:0] row_border_data_rd,
    input  logic              frame_vsync,
    input  logic              frame_hsync,
    input  logic              frame_de,
    input  logic [10:0]       xpos,
    input  logic [10:0]       ypos,
    input  logic [23:0]       pixel_data,
    output logic              out_vsync,
    output logic              out_hsync,
    output logic              out_de,
    output logic [23:0]       out_pixel,
    output logic              box_valid
);

    localparam int NUM_RD = 2 * NUM_COL + 2 * NUM_ROW;
    localparam int NB     = NUM_COL * NUM_ROW;

    state_t     state;
    logic       done_d;
    logic       vsync_d;
    logic [7:0] ld_cnt;
    logic [7:0] nxt_issue;
    logic [7:0] cap_idx;

    coord_t     pend_col_l [NUM_COL];
    coord_t     pend_col_r [NUM_COL];
    coord_t     pend_row_t [NUM_ROW];
    coord_t     pend_row_b [NUM_ROW];
    coord_t     act_col_l  [NUM_COL];
    coord_t     act_col_r  [NUM_COL];
    coord_t     act_row_t  [NUM_ROW];
    coord_t     act_row_b  [NUM_ROW];
    logic [3:0] pend_ncol;
    logic [3:0] pend_nrow;
    logic [3:0] act_ncol;
    logic [3:0] act_nrow;

    assign nxt_issue = ld_cnt + 8'd1;
    assign cap_idx   = ld_cnt - 8'd1;
    assign box_valid = (act_ncol != 4'd0) && (act_nrow != 4'd0);

    // Left/top edges come from a -2 offset upstream, so an out-of-range value is an underflow.
    function automatic coord_t clamp_lo(input logic [DEPBIT-1:0] d, input logic [31:0] lim);
        return (32'(d) >= lim) ? '0 : coord_t'(d);
    endfunction

    function automatic coord_t clamp_hi(input logic [DEPBIT-1:0] d, input logic [31:0] lim);
        return (32'(d) >= lim) ? coord_t'(lim - 32'd1) : coord_t'(d);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            done_d             <= 1'b0;
            vsync_d            <= 1'b0;
            ld_cnt             <= '0;
            col_border_addr_rd <= '0;
            row_border_addr_rd <= '0;
            pend_ncol          <= '0;
            pend_nrow          <= '0;
            act_ncol           <= '0;
            act_nrow           <= '0;
            for (int i = 0; i < NUM_COL; i++) begin
                pend_col_l[i] <= '0;
                pend_col_r[i] <= '0;
                act_col_l[i]  <= '0;
                act_col_r[i]  <= '0;
            end
            for (int j = 0; j < NUM_ROW; j++) begin
                pend_row_t[j] <= '0;
                pend_row_b[j] <= '0;
                act_row_t[j]  <= '0;
                act_row_b[j]  <= '0;
            end
        end else begin
            done_d  <= project_done_flag;
            vsync_d <= frame_vsync;
            case (state)
                IDLE: begin
                    if (project_done_flag && !done_d) begin
                        state              <= LOAD;
                        ld_cnt             <= '0;
                        col_border_addr_rd <= DEPBIT'(1);
                        row_border_addr_rd <= '0;
                        pend_ncol          <= num_col;
                        pend_nrow          <= num_row;
                    end
                end
                LOAD: begin
                    // Data on the read ports belongs to the address issued one cycle earlier.
                    if (ld_cnt != 8'd0) begin
                        for (int i = 0; i < NUM_COL; i++) begin
                            if (cap_idx == 8'(2 * i))
                                pend_col_l[i] <= clamp_lo(col_border_data_rd, 32'(H_PIXEL));
                            if (cap_idx == 8'(2 * i + 1))
                                pend_col_r[i] <= clamp_hi(col_border_data_rd, 32'(H_PIXEL));
                        end
                        for (int j = 0; j < NUM_ROW; j++) begin
                            if (cap_idx == 8'(2 * NUM_COL + 2 * j))
                                pend_row_t[j] <= clamp_lo(row_border_data_rd, 32'(V_PIXEL));
                            if (cap_idx == 8'(2 * NUM_COL + 2 * j + 1))
                                pend_row_b[j] <= clamp_hi(row_border_data_rd, 32'(V_PIXEL));
                        end
                    end
                    if (ld_cnt == 8'(NUM_RD)) begin
                        state              <= ARMED;
                        col_border_addr_rd <= '0;
                        row_border_addr_rd <= '0;
                    end else begin
                        ld_cnt <= nxt_issue;
                        col_border_addr_rd <= (nxt_issue < 8'(2 * NUM_COL)) ?
                                              DEPBIT'(nxt_issue + 8'd1) : '0;
                        row_border_addr_rd <= (nxt_issue >= 8'(2 * NUM_COL) && nxt_issue < 8'(NUM_RD)) ?
                                              DEPBIT'(nxt_issue - 8'(2 * NUM_COL) + 8'd1) : '0;
                    end
                end
                ARMED: begin
                    if (vsync_d && !frame_vsync) begin
                        state    <= IDLE;
                        act_ncol <= (pend_ncol > 4'(NUM_COL)) ? 4'(NUM_COL) : pend_ncol;
                        act_nrow <= (pend_nrow > 4'(NUM_ROW)) ? 4'(NUM_ROW) : pend_nrow;
                        act_col_l <= pend_col_l;
                        act_col_r <= pend_col_r;
                        act_row_t <= pend_row_t;
                        act_row_b <= pend_row_b;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [NB-1:0] hit_c;
    logic [NB-1:0] hit_q;
`ifdef DIGIT_BOX_FILL_EN
    logic [NB-1:0] inside_c;
    logic [NB-1:0] inside_q;
`endif

    for (genvar i = 0; i < NUM_COL; i++) begin : g_col
        for (genvar j = 0; j < NUM_ROW; j++) begin : g_row
            box_t bx;
            logic en;
            assign bx = '{l: act_col_l[i], r: act_col_r[i], t: act_row_t[j], b: act_row_b[j]};
            assign en = (4'(i) < act_ncol) && (4'(j) < act_nrow);
            box_hit #(.LINE_W(LINE_W)) u_box_hit (
                .en     (en),
                .box    (bx),
                .x      (xpos),
                .y      (ypos),
`ifdef DIGIT_BOX_FILL_EN
                .inside (inside_c[i * NUM_ROW + j]),
`endif
                .hit    (hit_c[i * NUM_ROW + j])
            );
        end
    end

    rgb_t pix_q;
    logic vs_q;
    logic hs_q;
    logic de_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_q     <= '0;
`ifdef DIGIT_BOX_FILL_EN
            inside_q  <= '0;
`endif
            pix_q     <= '0;
            vs_q      <= 1'b0;
            hs_q      <= 1'b0;
            de_q      <= 1'b0;
            out_vsync <= 1'b0;
            out_hsync <= 1'b0;
            out_de    <= 1'b0;
            out_pixel <= '0;
        end else begin
            hit_q     <= hit_c;
`ifdef DIGIT_BOX_FILL_EN
            inside_q  <= inside_c;
`endif
            pix_q     <= pixel_data;
            vs_q      <= frame_vsync;
            hs_q      <= frame_hsync;
            de_q      <= frame_de;
            out_vsync <= vs_q;
            out_hsync <= hs_q;
            out_de    <= de_q;
            if (de_q && (|hit_q))
                out_pixel <= BOX_COLOR;
`ifdef DIGIT_BOX_FILL_EN
            else if (de_q && (|inside_q))
                out_pixel <= rgb_avg(pix_q, BOX_COLOR);
`endif
            else
                out_pixel <= pix_q;
        end
    end

endmodule

// File: tb/tb_digit_box_overlay.sv
// tb/tb_digit_box_overlay.sv - scoreboard bench for digit_box_overlay (DIGIT_BOX_FILL_EN changes interior expectations)
module tb_digit_box_overlay;

    localparam logic [23:0] RED = 24'hFF0000;
    localparam logic [23:0] GRN = 24'h00FF00;
`ifdef DIGIT_BOX_FILL_EN
    localparam logic [23:0] INT_EXP = 24'h7F7F00;
`else
    localparam logic [23:0] INT_EXP = 24'h00FF00;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        done = 1'b0;
    logic [3:0]  num_col = 4'd5;
    logic [3:0]  num_row = 4'd1;
    logic [12:0] col_addr;
    logic [12:0] row_addr;
    logic [12:0] col_data = '0;
    logic [12:0] row_data = '0;
    logic        vs = 1'b0;
    logic        hs = 1'b0;
    logic        de = 1'b0;
    logic [10:0] x = '0;
    logic [10:0] y = '0;
    logic [23:0] pix = '0;
    logic        o_vs;
    logic        o_hs;
    logic        o_de;
    logic [23:0] o_pix;
    logic        box_valid;

    logic [12:0] col_ram [16];
    logic [12:0] row_ram [16];

    int          n_vec = 0;
    int          n_err = 0;
    logic [23:0] exp_q [$];
    string       name_q [$];
    logic [23:0] exp_pix;
    string       exp_name;

    always #5 clk = ~clk;

    digit_box_overlay dut (
        .clk                (clk),
        .rst                (rst),
        .project_done_flag  (done),
        .num_col            (num_col),
        .num_row            (num_row),
        .col_border_addr_rd (col_addr),
        .col_border_data_rd (col_data),
        .row_border_addr_rd (row_addr),
        .row_border_data_rd (row_data),
        .frame_vsync        (vs),
        .frame_hsync        (hs),
        .frame_de           (de),
        .xpos               (x),
        .ypos               (y),
        .pixel_data         (pix),
        .out_vsync          (o_vs),
        .out_hsync          (o_hs),
        .out_de             (o_de),
        .out_pixel          (o_pix),
        .box_valid          (box_valid)
    );

    always @(posedge clk) begin
        col_data <= col_ram[col_addr[3:0]];
        row_data <= row_ram[row_addr[3:0]];
    end

    always @(negedge clk) begin
        if (o_de === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_pixel: got %06h with nothing expected", o_pix);
            end else begin
                exp_pix  = exp_q.pop_front();
                exp_name = name_q.pop_front();
                if (o_pix !== exp_pix) begin
                    n_err++;
                    $display("FAIL %s: got %06h expected %06h", exp_name, o_pix, exp_pix);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_pix(input string name, input int px, input int py,
                            input logic [23:0] p, input logic [23:0] e);
        de  = 1'b1;
        x   = 11'(px);
        y   = 11'(py);
        pix = p;
        exp_q.push_back(e);
        name_q.push_back(name);
        tick;
        de = 1'b0;
    endtask

    task automatic pulse_done;
        done = 1'b1;
        tick;
        tick;
        done = 1'b0;
        repeat (14) tick;
    endtask

    task automatic vsync_fall;
        vs = 1'b1;
        tick;
        vs = 1'b0;
        tick;
        tick;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            col_ram[i] = 13'(700 + 100 * i);
            row_ram[i] = 13'(600);
        end
        col_ram[1] = 13'd100; col_ram[2] = 13'd200; col_ram[3] = 13'd300;
        col_ram[4] = 13'd400; col_ram[5] = 13'd500; col_ram[6] = 13'd600;
        row_ram[1] = 13'd50;  row_ram[2] = 13'd150;

        repeat (3) tick;
        check("rst_out_pixel", 32'(o_pix), 32'h0);
        check("rst_out_de", 32'(o_de), 32'h0);
        check("rst_box_valid", 32'(box_valid), 32'h0);
        check("rst_col_addr", 32'(col_addr), 32'h0);
        check("rst_row_addr", 32'(row_addr), 32'h0);
        rst = 1'b0;
        tick;

        send_pix("no_box_pass", 100, 50, 24'h123456, 24'h123456);
        hs = 1'b1;
        tick;
        hs = 1'b0;
        check("hsync_lat1", 32'(o_hs), 32'h0);
        tick;
        check("hsync_lat2", 32'(o_hs), 32'h1);
        tick;

        pulse_done;
        check("armed_not_committed", 32'(box_valid), 32'h0);
        vsync_fall;
        check("committed_box_valid", 32'(box_valid), 32'h1);

        send_pix("b0_top_left", 100, 50, 24'h123456, RED);
        send_pix("b0_right", 200, 120, 24'h123456, RED);
        send_pix("b0_interior", 150, 100, GRN, INT_EXP);
        send_pix("b0_left_w2", 101, 100, 24'h123456, RED);
        send_pix("b0_left_w3", 102, 100, GRN, INT_EXP);
        send_pix("b0_top_w2", 150, 51, 24'h123456, RED);
        send_pix("b0_right_out", 201, 100, 24'h123456, 24'h123456);
        send_pix("gap_pass", 250, 50, 24'h654321, 24'h654321);
        send_pix("b1_bottom", 350, 150, 24'h123456, RED);
        send_pix("b2_bottom_w2", 550, 149, 24'h123456, RED);
        send_pix("b3_not_drawn", 700, 50, 24'h0A0B0C, 24'h0A0B0C);
        send_pix("above_top", 100, 49, 24'h111111, 24'h111111);
        send_pix("below_bottom", 100, 151, 24'h222222, 24'h222222);
        repeat (3) tick;

        col_ram[1] = 13'd2047; col_ram[2] = 13'd40;
        col_ram[3] = 13'd1000; col_ram[4] = 13'd1100;
        col_ram[5] = 13'd1200; col_ram[6] = 13'd1300;
        row_ram[1] = 13'd10;   row_ram[2] = 13'd800;
        pulse_done;
        send_pix("mid_old_box", 100, 50, 24'h123456, RED);
        send_pix("mid_new_absent", 0, 20, 24'h333333, 24'h333333);
        repeat (3) tick;
        vsync_fall;

        send_pix("clamp_left_x0", 0, 20, 24'h333333, RED);
        send_pix("old_box_gone", 100, 50, 24'h123456, 24'h123456);
        send_pix("clamp_bottom", 20, 719, 24'h123456, RED);
        send_pix("clamp_bottom_w2", 20, 718, 24'h123456, RED);
        send_pix("b0_new_interior", 20, 717, GRN, INT_EXP);
        send_pix("clamp_right", 1279, 300, 24'h123456, RED);
        send_pix("clamp_right_w2", 1278, 300, 24'h123456, RED);
        send_pix("b2_new_interior", 1277, 300, GRN, INT_EXP);
        send_pix("b2_new_left", 1200, 300, 24'h123456, RED);
        send_pix("new_gap", 1150, 300, 24'h444444, 24'h444444);
        repeat (3) tick;

        pix = 24'hABCDEF;
        hs  = 1'b1;
        done = 1'b1;
        repeat (3) tick;
        check("pre_rst_pixel", 32'(o_pix), 32'hABCDEF);
        check("pre_rst_box_valid", 32'(box_valid), 32'h1);
        rst  = 1'b1;
        done = 1'b0;
        tick;
        check("rst_load_pixel", 32'(o_pix), 32'h0);
        check("rst_load_hsync", 32'(o_hs), 32'h0);
        check("rst_load_box_valid", 32'(box_valid), 32'h0);
        check("rst_load_col_addr", 32'(col_addr), 32'h0);
        rst = 1'b0;
        hs  = 1'b0;
        repeat (14) tick;
        vsync_fall;
        check("post_rst_box_valid", 32'(box_valid), 32'h0);
        send_pix("post_rst_pass0", 0, 20, 24'h555555, 24'h555555);
        send_pix("post_rst_pass1", 1200, 300, 24'h666666, 24'h666666);
        repeat (5) tick;

        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
